// File: rtl/spmv_mac.sv
// Multi-channel sparse matrix-vector multiply-accumulate: per-channel product pipeline,
// row accumulation into a 2-entry result queue, and a round-robin result arbiter.
module spmv_mac #(
  parameter int unsigned channel_num = 4,
  parameter int unsigned val_bits    = 8,
  parameter int unsigned acc_bits    = 24,
  parameter int unsigned row_id_size = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [channel_num*val_bits-1:0]   vec,
  input  logic [channel_num-1:0]            vec_fifo_empty,
  output logic [channel_num-1:0]            vec_fifo_read,
  input  logic [channel_num*val_bits-1:0]   mat_val,
  input  logic [channel_num-1:0]            mat_last,
  input  logic [channel_num-1:0]            mat_fifo_empty,
  output logic [channel_num-1:0]            mat_fifo_read,
  output logic [acc_bits-1:0]               res,
  output logic [$clog2(channel_num)-1:0]    res_ch,
  output logic [row_id_size-1:0]            res_row,
  output logic                              res_valid,
  input  logic                              res_ready
);

  localparam int unsigned ChW = $clog2(channel_num);

  logic [channel_num-1:0] pop;
  logic [channel_num-1:0] nonempty;
  logic [acc_bits-1:0]    head_res [channel_num];
  logic [row_id_size-1:0] head_row [channel_num];

  logic [ChW-1:0] rr_ptr_q;
  logic [ChW-1:0] sel;
  logic           any_sel;
  logic           lock_q;
  logic [ChW-1:0] lock_ch_q;

  assign vec_fifo_read = pop;
  assign mat_fifo_read = pop;

  for (genvar c = 0; c < channel_num; c++) begin : g_ch
    logic signed [val_bits-1:0]   m_s;
    logic signed [val_bits-1:0]   v_s;
    logic signed [2*val_bits-1:0] p_s;
    logic [acc_bits-1:0]          prod;
    logic [1:0]                   n_last;
    logic                         credit;
    logic                         push;
    logic                         qpop;
    logic [acc_bits-1:0]          push_res;

    // dv_q marks that this channel's FIFO douts carry popped data this cycle
    logic                   dv_q;
    logic                   s1_valid_q;
    logic                   s1_last_q;
    logic [acc_bits-1:0]    s1_prod_q;
    logic [acc_bits-1:0]    acc_q;
    logic [row_id_size-1:0] row_q;
    logic [1:0]             occ_q;
    logic [acc_bits-1:0]    q_res_q [2];
    logic [row_id_size-1:0] q_row_q [2];

    assign m_s  = mat_val[c*val_bits +: val_bits];
    assign v_s  = vec[c*val_bits +: val_bits];
    assign p_s  = (2*val_bits)'(m_s) * (2*val_bits)'(v_s);
    assign prod = acc_bits'(p_s);

    // Reserve a queue slot for every row end already in flight before popping again
    assign n_last = {1'b0, dv_q & mat_last[c]} + {1'b0, s1_valid_q & s1_last_q};
    assign credit = (2'd2 - occ_q) > n_last;
    assign pop[c] = ~vec_fifo_empty[c] & ~mat_fifo_empty[c] & credit & ~rst;

    assign push     = s1_valid_q & s1_last_q;
    assign push_res = acc_q + s1_prod_q;
    assign qpop     = res_valid & res_ready & (sel == ChW'(c));

    assign nonempty[c] = (occ_q != 2'd0);
    assign head_res[c] = q_res_q[0];
    assign head_row[c] = q_row_q[0];

    always_ff @(posedge clk) begin
      if (rst) begin
        dv_q       <= 1'b0;
        s1_valid_q <= 1'b0;
        s1_last_q  <= 1'b0;
        s1_prod_q  <= '0;
        acc_q      <= '0;
        row_q      <= '0;
        occ_q      <= 2'd0;
        q_res_q[0] <= '0;
        q_res_q[1] <= '0;
        q_row_q[0] <= '0;
        q_row_q[1] <= '0;
      end else begin
        dv_q       <= pop[c];
        s1_valid_q <= dv_q;
        s1_last_q  <= mat_last[c];
        s1_prod_q  <= prod;

        if (s1_valid_q) begin
          if (s1_last_q) begin
            acc_q <= '0;
            row_q <= row_q + row_id_size'(1);
          end else begin
            acc_q <= push_res;
          end
        end

        case ({push, qpop})
          2'b10: begin
            if (occ_q == 2'd0) begin
              q_res_q[0] <= push_res;
              q_row_q[0] <= row_q;
            end else begin
              q_res_q[1] <= push_res;
              q_row_q[1] <= row_q;
            end
            occ_q <= occ_q + 2'd1;
          end
          2'b01: begin
            q_res_q[0] <= q_res_q[1];
            q_row_q[0] <= q_row_q[1];
            occ_q      <= occ_q - 2'd1;
          end
          2'b11: begin
            if (occ_q == 2'd1) begin
              q_res_q[0] <= push_res;
              q_row_q[0] <= row_q;
            end else begin
              q_res_q[0] <= q_res_q[1];
              q_row_q[0] <= q_row_q[1];
              q_res_q[1] <= push_res;
              q_row_q[1] <= row_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A stalled grant stays locked so a newly filled queue cannot preempt it
  always_comb begin
    int unsigned idx;
    idx     = 0;
    sel     = lock_ch_q;
    any_sel = 1'b0;
    if (lock_q) begin
      any_sel = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= channel_num; i++) begin
        idx = (int'(rr_ptr_q) + i) % channel_num;
        if (!any_sel && nonempty[idx]) begin
          any_sel = 1'b1;
          sel     = ChW'(idx);
        end
      end
    end
  end

  assign res_valid = any_sel & ~rst;
  assign res       = head_res[sel];
  assign res_ch    = sel;
  assign res_row   = head_row[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= ChW'(channel_num - 1);
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= res_valid & ~res_ready;
      lock_ch_q <= sel;
      if (res_valid && res_ready) begin
        rr_ptr_q <= sel;
      end
    end
  end

endmodule

// File: doc/spmv_mac.md
SPMV_MAC -- requirements
Module: spmv_mac

Interface
- REQ-001 SHALL have parameter channel_num, default 4: number of parallel multiply channels; matches the upstream vector-fetch stage.
- REQ-002 SHALL have parameter val_bits, default 8: signed matrix and vector value width.
- REQ-003 SHALL have parameter acc_bits, default 24: signed accumulator and result width, at least 2*val_bits.
- REQ-004 SHALL have parameter row_id_size, default 16: per-channel row counter width.
- REQ-005 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
- REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-007 SHALL have port vec, input, channel_num*val_bits: vector-value FIFO douts; channel c is at bits [c*val_bits +: val_bits].
- REQ-008 SHALL have port vec_fifo_empty, input, channel_num: vector FIFO empty flags.
- REQ-009 SHALL have port vec_fifo_read, output, channel_num: vector FIFO read strobes.
- REQ-010 SHALL have port mat_val, input, channel_num*val_bits: matrix nonzero-value FIFO douts, same packing as vec.
- REQ-011 SHALL have port mat_last, input, channel_num: flag from the matrix FIFO marking the final nonzero of a row; it travels with mat_val.
- REQ-012 SHALL have port mat_fifo_empty, input, channel_num: matrix FIFO empty flags.
- REQ-013 SHALL have port mat_fifo_read, output, channel_num: matrix FIFO read strobes.
- REQ-014 SHALL have port res, output, acc_bits: completed row dot-product.
- REQ-015 SHALL have port res_ch, output, clog2(channel_num): channel that produced res.
- REQ-016 SHALL have port res_row, output, row_id_size: that channel's row index.
- REQ-017 SHALL have port res_valid, output, 1 bit: result valid.
- REQ-018 SHALL have port res_ready, input, 1 bit: downstream accepts the result.

Function
- REQ-019 SHALL treat both input FIFOs as standard mode: dout is valid in the cycle after the read strobe.
- REQ-020 SHALL, per channel c, drive vec_fifo_read[c] and mat_fifo_read[c] identically and combinationally. Both are high iff ~vec_fifo_empty[c], ~mat_fifo_empty[c] and the channel has pop credit (REQ-024).
- REQ-021 SHALL, in stage S1 (pop cycle +1), register the sign-extended product mat_val*vec together with mat_last and a valid bit.
- REQ-022 SHALL, in stage S2 (pop cycle +2), handle S1 valid as follows:
  - not last: acc <= acc + product;
  - last: push acc + product and the row counter into the channel's 2-entry result queue, then clear acc to 0 and increment the row counter.
- REQ-023 SHALL wrap accumulation and the row counter modulo 2^acc_bits and 2^row_id_size respectively; no saturation and no error flag.
- REQ-024 SHALL grant pop credit iff (2 - queue occupancy) > (number of valid last-flagged entries in S1 and S2 of that channel). The queue therefore never overflows and never drops a result.
- REQ-025 SHALL run the output arbiter round-robin over channels with non-empty queues.
  - The search starts at the channel after the last one granted.
  - The selected head drives res, res_ch and res_row with res_valid=1.
- REQ-026 SHALL hold res, res_ch, res_row and res_valid stable while res_valid & ~res_ready. A pop occurs only on res_valid & res_ready.
- REQ-027 SHALL allow a queue to be pushed (S2) and popped (output) in the same cycle; occupancy is then unchanged.
- REQ-028 SHALL present results with no bubble between back-to-back grants when res_ready stays high.
- REQ-029 SHALL have no cross-channel ordering guarantee. Order within one channel is preserved.

Reset
- REQ-030 SHALL, while rst=1 at a clock edge, clear every acc, row counter, S1/S2 valid bit, queue and the round-robin pointer. After reset the pointer makes channel 0 first in priority.
- REQ-031 SHALL hold vec_fifo_read, mat_fifo_read and res_valid at 0 during any cycle in which rst=1.
- REQ-032 SHALL discard partial sums and in-flight products on mid-operation reset. Upstream FIFOs are the environment's responsibility.

Verification
- REQ-033 Single row: ch0 mat {2,3,-1(last)}, vec {5,4,7}, res_ready=1 -> one result res=15, res_ch=0, res_row=0, valid no earlier than 4 cycles after the first pop.
- REQ-034 Backpressure: ch0 completes rows summing 10, 20 and 30 with res_ready=0 -> reads stop once 2 results are queued and the 3rd is in flight. After res_ready=1 the outputs are 10, 20, 30 in order, with res_row 0, 1, 2.
- REQ-035 Round-robin: all 4 channels each hold one queued result, res_ready=1 -> res_ch sequence 0, 1, 2, 3 on consecutive cycles.
- REQ-036 Wrap: acc_bits=16, val_bits=8, ch1 row of three 127*127 products -> res=48387 mod 65536 interpreted signed = -17149.
- REQ-037 Reset mid-row: rst pulsed after 2 non-last pops on ch2, then row {1*1(last)} -> res=1, res_row=0.
- REQ-038 Stall balance: vec_fifo_empty[0] toggles randomly while the matrix FIFO is full -> the two read strobes on ch0 are always equal, and the sum matches a reference model.
